password_sequence_sender: RTL and testbench
===========================================

# password_sequence_sender

Serial digit transmitter that presents a stored multi-digit code, one digit per clock, on a 4-bit `digit` bus. It is the initiator side of the serial password lock's digit interface, used by the bench harness and the auto-unlock path. A `start` pulse latches the code, the sequence is played out with optional idle gaps between digits, and a `done` pulse marks completion. Admin mode plays the fixed lockdown-clear sequence 0,1,2,9 instead of the code.

## Interface
- `DIGITS`, 4: number of code digits sent in normal mode; legal range 1..8.
- `GAP`, 0: idle cycles inserted between consecutive digits, none after the last; legal range 0..15.
- `IDLE_DIGIT`, 4'hF: value driven on `digit` whenever `digitValid`=0.
- `CLK` input 1: single clock; all state updates on posedge.
- `RST` input 1: asynchronous, active-low reset.
- `start` input 1: request; sampled only in S_IDLE.
- `adminMode` input 1: sampled with `start`; 1 selects the sequence 0,1,2,9.
- `code` input 4*DIGITS: digit k at `code[4k+3:4k]`; digit 0 is sent first.
- `digit` output 4: current digit.
- `digitValid` output 1: `digit` carries a sequence digit this cycle.
- `busy` output 1: sequence in progress.
- `done` output 1: one-cycle completion pulse.
- `err` output 1: one-cycle rejection pulse (only with the macro below; tied 0 otherwise).

## Operation
- Reset values: `digit`=IDLE_DIGIT, `digitValid`=0, `busy`=0, `done`=0, `err`=0; FSM in S_IDLE; counters cleared.
- FSM states: S_IDLE, S_SEND, S_GAP, S_DONE.
- S_IDLE: on `start`=1, latch `code` (or the constant 0,1,2,9 if `adminMode`=1) into a shift register, set length L = DIGITS (normal) or 4 (admin), clear digit index, go to S_SEND. Otherwise stay.
- S_SEND: drive `digit` from the shift register, `digitValid`=1. If index = L-1, go to S_DONE. Otherwise increment the index and go to S_GAP when GAP>0, or stay in S_SEND when GAP=0.
- S_GAP: `digitValid`=0 and `digit`=IDLE_DIGIT for exactly GAP cycles, then go to S_SEND.
- S_DONE: `done`=1 for one cycle, then go to S_IDLE.
- `busy`=1 in S_SEND and S_GAP only.
- `start` outside S_IDLE is ignored and not queued. `code` and `adminMode` changes after latching have no effect.
- Index counter width is $clog2(8); gap counter width is 4 bits. No wrap is reachable because the index stops at L-1.
- Reset asserted mid-sequence: all outputs take their reset values immediately (asynchronous). The sequence is abandoned and no `done` pulse is issued.

## Timing
- `start` sampled at edge t. First digit is visible in cycle t+1 (latency 1).
- Digit k appears in cycle t+1+k*(GAP+1). Each digit is valid for exactly one cycle.
- `done` is high in cycle t+1+(L-1)*(GAP+1)+1. The earliest next accepted `start` is sampled at the edge ending that S_DONE cycle plus one, i.e. in the following S_IDLE cycle.
- Total occupancy from `start` to return to S_IDLE: L + (L-1)*GAP + 1 cycles.

## Configuration
- `PSS_BCD_CHECK_EN` defined: in S_IDLE on `start` with `adminMode`=0, if any latched digit is greater than 9, the block pulses `err`=1 for one cycle (t+1), sends nothing, does not assert `busy` or `done`, and stays in S_IDLE. The admin sequence is never checked.
- `PSS_BCD_CHECK_EN` undefined: digits are sent unchecked, and `err` is a constant 0.

## Test plan
- DIGITS=4, GAP=0, `code`=16'h4321, `start` at t -> `digit` = 1,2,3,4 in cycles t+1..t+4 with `digitValid`=1; `done`=1 in t+5; `busy`=1 in t+1..t+4 only.
- GAP=2, `code`=16'h9075 -> digits 5,0,7,9 in cycles t+1, t+4, t+7, t+10; `digit`=4'hF with `digitValid`=0 in the gap cycles; `done` in t+11.
- `adminMode`=1, `code`=16'hFFFF -> 0,1,2,9 in t+1..t+4 and `done` in t+5. Repeat with BCD check enabled -> `err` stays 0.
- Second `start` pulsed during `busy`, and `code` changed mid-sequence -> the original digits complete unchanged and only one `done` pulse is issued.
- `RST` low during the third digit -> outputs return to their reset values in the same cycle, no `done` pulse; after release, a fresh `start` sends the full sequence.
- With `PSS_BCD_CHECK_EN`, `code`=16'h12A4 -> `err`=1 in t+1 only, `digitValid`, `busy` and `done` stay 0. Without the macro, the same code sends 4,A,2,1.

Source files
------------

// File: rtl/password_sequence_sender.sv
// Serial digit transmitter: plays a latched code (or the admin sequence 0,1,2,9) one digit per clock.
// Optional BCD validation of the normal-mode code is enabled by defining PSS_BCD_CHECK_EN.
module password_sequence_sender #(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned GAP        = 0,
  parameter logic [3:0]  IDLE_DIGIT = 4'hF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  adminMode_i,
  input  logic [4*DIGITS-1:0]   code_i,
  output logic [3:0]            digit_o,
  output logic                  digitValid_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  // The shift register must hold at least four digits so the admin sequence fits.
  localparam int unsigned SR_DIGITS   = (DIGITS > 4) ? DIGITS : 4;
  localparam int unsigned SR_W        = 4 * SR_DIGITS;
  localparam int unsigned IDX_W       = $clog2(8);
  localparam bit          HAS_GAP     = (GAP != 0);
  localparam logic [3:0]  GAP_LAST    = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
  localparam logic [IDX_W-1:0] LAST_NORMAL = IDX_W'(DIGITS - 1);
  localparam logic [IDX_W-1:0] LAST_ADMIN  = IDX_W'(3);
  localparam logic [15:0] ADMIN_SEQ   = 16'h9210;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [SR_W-1:0]   shift_q, shift_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  lastIdx_q, lastIdx_d;
  logic [3:0]        gapCnt_q, gapCnt_d;
  logic              accept;

`ifdef PSS_BCD_CHECK_EN
  logic badCode;
  logic err_q, err_d;

  always_comb begin
    badCode = 1'b0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (code_i[4*k +: 4] > 4'd9) badCode = 1'b1;
    end
  end

  assign accept  = start_i && !(!adminMode_i && badCode);
  assign err_d   = (state_q == S_IDLE) && start_i && !adminMode_i && badCode;
  assign err_o   = err_q;
`else
  assign accept  = start_i;
  assign err_o   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      idx_q     <= '0;
      lastIdx_q <= '0;
      gapCnt_q  <= '0;
`ifdef PSS_BCD_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      lastIdx_q <= lastIdx_d;
      gapCnt_q  <= gapCnt_d;
`ifdef PSS_BCD_CHECK_EN
      err_q     <= err_d;
`endif
    end
  end

  // The current digit always sits in the low nibble; the register shifts right as digits go out.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    idx_d        = idx_q;
    lastIdx_d    = lastIdx_q;
    gapCnt_d     = gapCnt_q;
    digit_o      = IDLE_DIGIT;
    digitValid_o = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (adminMode_i) begin
            shift_d   = SR_W'(ADMIN_SEQ);
            lastIdx_d = LAST_ADMIN;
          end else begin
            shift_d   = SR_W'(code_i);
            lastIdx_d = LAST_NORMAL;
          end
          idx_d   = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        digit_o      = shift_q[3:0];
        digitValid_o = 1'b1;
        busy_o       = 1'b1;
        if (idx_q == lastIdx_q) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          shift_d = shift_q >> 4;
          if (HAS_GAP) begin
            gapCnt_d = '0;
            state_d  = S_GAP;
          end
        end
      end
      S_GAP: begin
        busy_o = 1'b1;
        if (gapCnt_q == GAP_LAST) begin
          state_d = S_SEND;
        end else begin
          gapCnt_d = gapCnt_q + 1'b1;
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_password_sequence_sender.sv
// Directed testbench for password_sequence_sender: one DUT with GAP=0 and one with GAP=2.
// Compile with PSS_BCD_CHECK_EN defined to exercise the BCD rejection path.
module tb_password_sequence_sender;

  typedef struct packed {
    logic [3:0] digit;
    logic       valid;
    logic       busy;
    logic       done;
    logic       err;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start0, start2;
  logic        adminMode;
  logic [15:0] code;

  logic [3:0] digit0, digit2;
  logic       valid0, valid2, busy0, busy2, done0, done2, err0, err2;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  password_sequence_sender #(.DIGITS(4), .GAP(0), .IDLE_DIGIT(4'hF)) dut0 (
    .clk(clk), .rst_n(rst_n), .start_i(start0), .adminMode_i(adminMode), .code_i(code),
    .digit_o(digit0), .digitValid_o(valid0), .busy_o(busy0), .done_o(done0), .err_o(err0)
  );

  password_sequence_sender #(.DIGITS(4), .GAP(2), .IDLE_DIGIT(4'hF)) dut2 (
    .clk(clk), .rst_n(rst_n), .start_i(start2), .adminMode_i(adminMode), .code_i(code),
    .digit_o(digit2), .digitValid_o(valid2), .busy_o(busy2), .done_o(done2), .err_o(err2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t observe(bit useGap);
    obs_t o;
    if (useGap) o = '{digit: digit2, valid: valid2, busy: busy2, done: done2, err: err2};
    else        o = '{digit: digit0, valid: valid0, busy: busy0, done: done0, err: err0};
    return o;
  endfunction

  // Expected outputs in cycle t+1+c after a start sampled at edge t, from the timing rules.
  function automatic obs_t expectAt(int c, int len, int gap, logic [31:0] digs);
    obs_t e;
    int   doneC;
    e     = '{digit: 4'hF, valid: 1'b0, busy: 1'b0, done: 1'b0, err: 1'b0};
    doneC = (len - 1) * (gap + 1) + 1;
    if (c == doneC) begin
      e.done = 1'b1;
    end else if (c < doneC) begin
      e.busy = 1'b1;
      if (c % (gap + 1) == 0) begin
        e.valid = 1'b1;
        e.digit = digs[4*(c/(gap+1)) +: 4];
      end
    end
    return e;
  endfunction

  task automatic applyStart(bit useGap);
    if (useGap) start2 = 1'b1; else start0 = 1'b1;
    tick();
    start0 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic test_reset();
    obs_t idle;
    idle = '{digit: 4'hF, valid: 1'b0, busy: 1'b0, done: 1'b0, err: 1'b0};
    rst_n = 1'b0; start0 = 1'b0; start2 = 1'b0; adminMode = 1'b0; code = 16'h0000;
    tick(); tick();
    for (int d = 0; d < 2; d++) begin
      compared++;
      if (observe(d == 1) !== idle) begin
        mismatched++;
        $display("[TB] FAIL reset dut%0d got=%b expected=%b", d * 2, observe(d == 1), idle);
      end
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    obs_t got, exp;
    code = 16'h4321; adminMode = 1'b0;
    applyStart(1'b0);
    for (int c = 0; c <= 5; c++) begin
      got = observe(1'b0);
      exp = expectAt(c, 4, 0, 32'h0000_4321);
      compared++;
      if (got !== exp) begin
        mismatched++;
        $display("[TB] FAIL basic cycle t+%0d got=%b expected=%b", c + 1, got, exp);
      end
      tick();
    end
  endtask

  task automatic test_gap();
    obs_t got, exp;
    code = 16'h9075; adminMode = 1'b0;
    applyStart(1'b1);
    for (int c = 0; c <= 11; c++) begin
      got = observe(1'b1);
      exp = expectAt(c, 4, 2, 32'h0000_9075);
      compared++;
      if (got !== exp) begin
        mismatched++;
        $display("[TB] FAIL gap cycle t+%0d got=%b expected=%b", c + 1, got, exp);
      end
      tick();
    end
  endtask

  task automatic test_admin();
    obs_t got, exp;
    code = 16'hFFFF; adminMode = 1'b1;
    applyStart(1'b0);
    adminMode = 1'b0;
    for (int c = 0; c <= 5; c++) begin
      got = observe(1'b0);
      exp = expectAt(c, 4, 0, 32'h0000_9210);
      compared++;
      if (got !== exp) begin
        mismatched++;
        $display("[TB] FAIL admin cycle t+%0d got=%b expected=%b", c + 1, got, exp);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    obs_t got, exp;
    int   doneCount;
    doneCount = 0;
    code = 16'h9075; adminMode = 1'b0;
    applyStart(1'b1);
    for (int c = 0; c <= 13; c++) begin
      got = observe(1'b1);
      exp = expectAt(c, 4, 2, 32'h0000_9075);
      if (got.done === 1'b1) doneCount++;
      compared++;
      if (got !== exp) begin
        mismatched++;
        $display("[TB] FAIL back_to_back cycle t+%0d got=%b expected=%b", c + 1, got, exp);
      end
      if (c >= 1 && c <= 4) begin
        start2 = 1'b1; code = 16'h8888; adminMode = 1'b1;
      end else begin
        start2 = 1'b0; adminMode = 1'b0;
      end
      tick();
    end
    start2 = 1'b0;
    compared++;
    if (doneCount !== 1) begin
      mismatched++;
      $display("[TB] FAIL back_to_back_done_count got=%0d expected=1", doneCount);
    end
  endtask

  task automatic test_reset_mid();
    obs_t got, exp, idle;
    int   doneCount;
    idle = '{digit: 4'hF, valid: 1'b0, busy: 1'b0, done: 1'b0, err: 1'b0};
    doneCount = 0;
    code = 16'h4321; adminMode = 1'b0;
    applyStart(1'b0);
    tick(); tick();
    exp = expectAt(2, 4, 0, 32'h0000_4321);
    got = observe(1'b0);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL reset_mid_third_digit got=%b expected=%b", got, exp);
    end
    #2 rst_n = 1'b0;
    #1;
    got = observe(1'b0);
    compared++;
    if (got !== idle) begin
      mismatched++;
      $display("[TB] FAIL reset_mid_immediate got=%b expected=%b", got, idle);
    end
    tick(); tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (observe(1'b0).done === 1'b1) doneCount++;
      tick();
    end
    compared++;
    if (doneCount !== 0) begin
      mismatched++;
      $display("[TB] FAIL reset_mid_no_done got=%0d expected=0", doneCount);
    end
    applyStart(1'b0);
    for (int c = 0; c <= 5; c++) begin
      got = observe(1'b0);
      exp = expectAt(c, 4, 0, 32'h0000_4321);
      compared++;
      if (got !== exp) begin
        mismatched++;
        $display("[TB] FAIL reset_mid_restart cycle t+%0d got=%b expected=%b", c + 1, got, exp);
      end
      tick();
    end
  endtask

  task automatic test_bcd();
    obs_t got, exp;
    code = 16'h12A4; adminMode = 1'b0;
    applyStart(1'b0);
    code = 16'h0000;
`ifdef PSS_BCD_CHECK_EN
    for (int c = 0; c <= 3; c++) begin
      got = observe(1'b0);
      exp = '{digit: 4'hF, valid: 1'b0, busy: 1'b0, done: 1'b0, err: (c == 0)};
      compared++;
      if (got !== exp) begin
        mismatched++;
        $display("[TB] FAIL bcd_reject cycle t+%0d got=%b expected=%b", c + 1, got, exp);
      end
      tick();
    end
`else
    for (int c = 0; c <= 5; c++) begin
      got = observe(1'b0);
      exp = expectAt(c, 4, 0, 32'h0000_12A4);
      compared++;
      if (got !== exp) begin
        mismatched++;
        $display("[TB] FAIL bcd_unchecked cycle t+%0d got=%b expected=%b", c + 1, got, exp);
      end
      tick();
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_admin();
    test_back_to_back();
    test_reset_mid();
    test_bcd();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
